// File: rtl/fcn_bist_pkg.sv
// Shared types and defaults for the fcn_bist self-test harness: FSM state encoding,
// default LFSR/MISR polynomials and the LFSR step function.
package fcn_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } bist_state_e;

    // Stored 16 bits wide and truncated to the instance width at the point of use.
    localparam logic [15:0] DEF_LFSR_TAPS = 16'h0014;
    localparam logic [15:0] DEF_LFSR_SEED = 16'hFFFF;
    localparam logic [15:0] DEF_MISR_TAPS = 16'hB400;

    // Fibonacci step: shift left, feed back the parity of the tapped bits into bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur,
                                              input logic [15:0] taps,
                                              input int width);
        logic [15:0] mask;
        logic        fb;
        mask = 16'((32'd1 << width) - 32'd1);
        fb   = ^(cur & taps);
        return ((cur << 1) | {15'd0, fb}) & mask;
    endfunction

endpackage

// File: rtl/fcn_bist_if.sv
// Controller + benchmark-side bundle of fcn_bist_driver. The harness uses the slave
// modport; whoever plays controller and benchmark together uses master.
interface fcn_bist_if
#(
    parameter int NUM_PI = 5,
    parameter int NUM_PO = 2,
    parameter int MISR_W = 16
);
    import fcn_bist_pkg::*;

    // start is a level sampled only while idle; busy covers LOAD..DONE; done is a
    // single-cycle pulse, and pass/signature hold from done until the next run loads.
    logic              start;
    logic [MISR_W-1:0] exp_sig;
    logic [NUM_PI-1:0] pi;
    logic [NUM_PO-1:0] po;
    logic              busy;
    logic              done;
    logic              pass;
    logic [MISR_W-1:0] signature;
    bist_state_e       state;

    modport master (
        output start, exp_sig, po,
        input  pi, busy, done, pass, signature, state
    );

    modport slave (
        input  start, exp_sig, po,
        output pi, busy, done, pass, signature, state
    );

endinterface

// File: rtl/fcn_bist_misr.sv
// Multiple-input signature register compacting the benchmark outputs; updates only on
// enabled edges, cleared synchronously at the start of each run.
module fcn_bist_misr
#(
    parameter int                MISR_W    = 16,
    parameter int                NUM_PO    = 2,
    parameter logic [MISR_W-1:0] MISR_TAPS = 16'hB400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic [NUM_PO-1:0] din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else if (clear) begin
            sig_q <= '0;
        end else if (en) begin
            sig_q <= {sig_q[MISR_W-2:0], 1'b0}
                   ^ (sig_q[MISR_W-1] ? MISR_TAPS : '0)
                   ^ MISR_W'(din);
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/fcn_bist_driver.sv
// BIST driver for a clocked benchmark: LFSR pattern source (binary up-counter when
// FCN_BIST_EXHAUSTIVE_EN is defined), latency-matched valid pipe, MISR compaction.
module fcn_bist_driver
    import fcn_bist_pkg::*;
#(
    parameter int                NUM_PI        = 5,
    parameter int                NUM_PO        = 2,
    parameter int                MISR_W        = 16,
    parameter int                PATTERN_COUNT = 31,
    parameter int                DUT_LATENCY   = 0,
    parameter logic [NUM_PI-1:0] LFSR_TAPS     = NUM_PI'(DEF_LFSR_TAPS),
    parameter logic [NUM_PI-1:0] LFSR_SEED     = NUM_PI'(DEF_LFSR_SEED),
    parameter logic [MISR_W-1:0] MISR_TAPS     = MISR_W'(DEF_MISR_TAPS)
) (
    input  logic     clk,
    input  logic     rst_n,
    fcn_bist_if.slave bus
);

    localparam int CNT_W  = NUM_PI + 1;
    localparam int PIPE_D = DUT_LATENCY + 1;

    bist_state_e       state_q;
    logic [NUM_PI-1:0] pi_q;
    logic [NUM_PI-1:0] src_q;
    logic [NUM_PI-1:0] src_next;
    logic [NUM_PI-1:0] src_init;
    logic [CNT_W-1:0]  cnt_q;
    logic [PIPE_D-1:0] vpipe_q;
    logic              pass_q;
    logic [MISR_W-1:0] sig;
    logic              last_pat;
    logic              pipe_empty;

    always_comb begin
`ifdef FCN_BIST_EXHAUSTIVE_EN
        src_next = src_q + NUM_PI'(1);
        src_init = '0;
`else
        src_next = NUM_PI'(lfsr_next(16'(src_q), 16'(LFSR_TAPS), NUM_PI));
        src_init = LFSR_SEED;
`endif
    end

    assign last_pat   = (cnt_q == CNT_W'(PATTERN_COUNT - 1));
    assign pipe_empty = (vpipe_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pi_q    <= '0;
            src_q   <= '0;
            cnt_q   <= '0;
            vpipe_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            // A pattern registered on this edge is tagged valid; the tag reaches the
            // pipe tail exactly when its benchmark response is on po.
            vpipe_q <= PIPE_D'({vpipe_q, state_q == RUN});
            case (state_q)
                IDLE: begin
                    if (bus.start) state_q <= LOAD;
                end
                LOAD: begin
                    src_q   <= src_init;
                    cnt_q   <= '0;
                    pass_q  <= 1'b0;
                    state_q <= RUN;
                end
                RUN: begin
                    pi_q  <= src_q;
                    src_q <= src_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_pat) state_q <= DRAIN;
                end
                DRAIN: begin
                    pi_q <= '0;
                    // The MISR is already final here: no capture happens once the pipe is empty.
                    if (pipe_empty) begin
                        pass_q  <= (sig == bus.exp_sig);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    fcn_bist_misr #(
        .MISR_W    (MISR_W),
        .NUM_PO    (NUM_PO),
        .MISR_TAPS (MISR_TAPS)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q == LOAD),
        .en    (vpipe_q[PIPE_D-1]),
        .din   (bus.po),
        .sig   (sig)
    );

    assign bus.pi        = pi_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.pass      = pass_q;
    assign bus.signature = sig;
    assign bus.state     = state_q;

endmodule
